// File: rtl/mtl1_bus_cycle_decoder.sv
// 6809 bus cycle decoder: address decode into RAM / I/O / flash-window selects,
// MRDY stretching while the SPI flash controller fetches data, with settle and timeout windows.
module mtl1_bus_cycle_decoder #(
    parameter logic [3:0]  FLASH_BASE     = 4'hF,
    parameter logic [7:0]  IO_BASE        = 8'hE0,
    parameter logic [15:0] RAM_TOP        = 16'hDFFF,
    parameter int          SETTLE_CYCLES  = 4,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic        i_RW,
    input  logic        i_VMA,
    input  logic        i_E,
    input  logic        i_flash_ready,
    input  logic [7:0]  i_flash_data,
    output logic        o_spi_ce,
    output logic        o_ram_ce,
    output logic        o_io_ce,
    output logic        o_MRDY,
    output logic [7:0]  o_DATA,
    output logic        o_flash_timeout,
    output logic        o_flash_wr_err
);

    localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYCLES - 1);
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        FLASH_SETTLE,
        FLASH_WAIT,
        HOLD
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic        r_eSync1;
    logic        r_eSync2;
    logic        r_eHist;
    logic [15:0] r_addr;
    logic        r_rw;
    logic [3:0]  r_settleCnt;
    logic [9:0]  r_timeoutCnt;
    logic        r_spiCe;
    logic        r_ramCe;
    logic        r_ioCe;
    logic        r_mrdy;
    logic [7:0]  r_data;
    logic        r_timeoutFlag;
    logic        r_wrErr;

    logic [15:0] w_addrNext;
    logic        w_rwNext;
    logic [3:0]  w_settleNext;
    logic [9:0]  w_timeoutNext;
    logic        w_spiCeNext;
    logic        w_ramCeNext;
    logic        w_ioCeNext;
    logic        w_mrdyNext;
    logic [7:0]  w_dataNext;
    logic        w_timeoutFlagNext;
    logic        w_wrErrNext;

    logic        w_eRise;
    logic        w_eFall;
    logic        w_hitFlash;
    logic        w_hitIo;
    logic        w_hitRam;
    logic [9:0]  w_timeoutInc;

    // E is asynchronous to clk; edges are taken from the synchronised copy only.
    assign w_eRise = r_eSync2 & ~r_eHist;
    assign w_eFall = ~r_eSync2 & r_eHist;

    assign w_hitFlash = (r_addr[15:12] == FLASH_BASE);
    assign w_hitIo    = (r_addr[15:8] == IO_BASE);
    assign w_hitRam   = (r_addr <= RAM_TOP);

    assign w_timeoutInc = (r_timeoutCnt == 10'h3FF) ? r_timeoutCnt : r_timeoutCnt + 10'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_eSync1      <= 1'b0;
            r_eSync2      <= 1'b0;
            r_eHist       <= 1'b0;
            r_addr        <= 16'h0000;
            r_rw          <= 1'b1;
            r_settleCnt   <= 4'd0;
            r_timeoutCnt  <= 10'd0;
            r_spiCe       <= 1'b0;
            r_ramCe       <= 1'b0;
            r_ioCe        <= 1'b0;
            r_mrdy        <= 1'b1;
            r_data        <= 8'hFF;
            r_timeoutFlag <= 1'b0;
            r_wrErr       <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_eSync1      <= i_E;
            r_eSync2      <= r_eSync1;
            r_eHist       <= r_eSync2;
            r_addr        <= w_addrNext;
            r_rw          <= w_rwNext;
            r_settleCnt   <= w_settleNext;
            r_timeoutCnt  <= w_timeoutNext;
            r_spiCe       <= w_spiCeNext;
            r_ramCe       <= w_ramCeNext;
            r_ioCe        <= w_ioCeNext;
            r_mrdy        <= w_mrdyNext;
            r_data        <= w_dataNext;
            r_timeoutFlag <= w_timeoutFlagNext;
            r_wrErr       <= w_wrErrNext;
        end
    end

    always_comb begin
        w_stateNext       = r_state;
        w_addrNext        = r_addr;
        w_rwNext          = r_rw;
        w_settleNext      = r_settleCnt;
        w_timeoutNext     = r_timeoutCnt;
        w_spiCeNext       = r_spiCe;
        w_ramCeNext       = r_ramCe;
        w_ioCeNext        = r_ioCe;
        w_mrdyNext        = r_mrdy;
        w_dataNext        = r_data;
        w_timeoutFlagNext = r_timeoutFlag;
        w_wrErrNext       = r_wrErr;

        case (r_state)
            IDLE: begin
                w_mrdyNext = 1'b1;
                if (w_eRise && i_VMA) begin
                    w_addrNext  = i_ADDRESS_BUS;
                    w_rwNext    = i_RW;
                    w_stateNext = DECODE;
                end
            end

            DECODE: begin
                w_stateNext = HOLD;
                if (w_hitFlash) begin
                    if (r_rw) begin
                        w_spiCeNext   = 1'b1;
                        w_mrdyNext    = 1'b0;
                        w_settleNext  = 4'd0;
                        w_timeoutNext = 10'd0;
                        w_stateNext   = FLASH_SETTLE;
                    end else begin
                        w_wrErrNext = 1'b1;
                    end
                end else if (w_hitIo) begin
                    w_ioCeNext = 1'b1;
                end else if (w_hitRam) begin
                    w_ramCeNext = 1'b1;
                end
            end

            // Ready never dropping means the controller already holds this address's data.
            FLASH_SETTLE: begin
                w_timeoutNext = w_timeoutInc;
                if (!i_flash_ready) begin
                    w_stateNext = FLASH_WAIT;
                end else if (r_settleCnt >= SETTLE_LAST) begin
                    w_dataNext  = i_flash_data;
                    w_mrdyNext  = 1'b1;
                    w_stateNext = HOLD;
                end else begin
                    w_settleNext = r_settleCnt + 4'd1;
                end
            end

            FLASH_WAIT: begin
                w_timeoutNext = w_timeoutInc;
                if (i_flash_ready) begin
                    w_dataNext  = i_flash_data;
                    w_mrdyNext  = 1'b1;
                    w_stateNext = HOLD;
                end else if (r_timeoutCnt >= TIMEOUT_LAST) begin
                    w_dataNext        = 8'hFF;
                    w_timeoutFlagNext = 1'b1;
                    w_mrdyNext        = 1'b1;
                    w_stateNext       = HOLD;
                end
            end

            HOLD: begin
                w_mrdyNext = 1'b1;
                if (w_eFall) begin
                    w_spiCeNext = 1'b0;
                    w_ramCeNext = 1'b0;
                    w_ioCeNext  = 1'b0;
                    w_stateNext = IDLE;
                end
            end

            default: begin
                w_spiCeNext = 1'b0;
                w_ramCeNext = 1'b0;
                w_ioCeNext  = 1'b0;
                w_mrdyNext  = 1'b1;
                w_stateNext = IDLE;
            end
        endcase
    end

    assign o_spi_ce        = r_spiCe;
    assign o_ram_ce        = r_ramCe;
    assign o_io_ce         = r_ioCe;
    assign o_MRDY          = r_mrdy;
    assign o_DATA          = r_data;
    assign o_flash_timeout = r_timeoutFlag;
    assign o_flash_wr_err  = r_wrErr;

endmodule

// File: tb/tb_mtl1_bus_cycle_decoder.sv
// Self-checking bench for mtl1_bus_cycle_decoder: directed and randomized bus cycles
// compared against an address-range reference model and expected flash timing.
module tb_mtl1_bus_cycle_decoder;

    localparam int K_NONE  = 0;
    localparam int K_RAM   = 1;
    localparam int K_IO    = 2;
    localparam int K_FLASH = 3;
    localparam int SETTLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 1023;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] iAddr;
    logic        iRw;
    logic        iVma;
    logic        iE;
    logic        iFlashReady;
    logic [7:0]  iFlashData;
    logic        o_spi_ce;
    logic        o_ram_ce;
    logic        o_io_ce;
    logic        o_MRDY;
    logic [7:0]  o_DATA;
    logic        o_flash_timeout;
    logic        o_flash_wr_err;

    int          checks = 0;
    int          failures = 0;
    bit          monOn = 1'b0;
    bit          seenSpi;
    bit          seenMrdyLow;
    logic [7:0]  expData;
    logic        expTimeout;
    logic        expWrErr;
    logic [15:0] rAddr;
    logic        rRw;
    logic [7:0]  rData;
    int          rSel;

    mtl1_bus_cycle_decoder dut (
        .clk             (clk),
        .reset           (rstN),
        .i_ADDRESS_BUS   (iAddr),
        .i_RW            (iRw),
        .i_VMA           (iVma),
        .i_E             (iE),
        .i_flash_ready   (iFlashReady),
        .i_flash_data    (iFlashData),
        .o_spi_ce        (o_spi_ce),
        .o_ram_ce        (o_ram_ce),
        .o_io_ce         (o_io_ce),
        .o_MRDY          (o_MRDY),
        .o_DATA          (o_DATA),
        .o_flash_timeout (o_flash_timeout),
        .o_flash_wr_err  (o_flash_wr_err)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [15:0] a);
        if (a >= 16'hF000) return K_FLASH;
        if (a >= 16'hE000 && a <= 16'hE0FF) return K_IO;
        if (a <= 16'hDFFF) return K_RAM;
        return K_NONE;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-wide invariants sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (monOn) begin
            if (o_spi_ce) seenSpi = 1'b1;
            if (!o_MRDY) seenMrdyLow = 1'b1;
            checkOutput("onehot_selects", 32'($countones({o_ram_ce, o_io_ce, o_spi_ce}) <= 1), 1);
            checkOutput("mrdy_low_only_flash", 32'(o_MRDY || o_spi_ce), 1);
        end
    end

    // dropAfter < 0: ready never drops; waitLen < 0: ready never returns.
    task automatic applyStimulus(input logic [15:0] addr, input logic rw, input int dropAfter,
                                 input int waitLen, input logic [7:0] d);
        int  kind;
        bit  flashRead;
        int  n;
        kind      = classify(addr);
        flashRead = (kind == K_FLASH) && rw;
        iAddr       = addr;
        iRw         = rw;
        iVma        = 1'b1;
        iFlashData  = (flashRead && dropAfter >= 0) ? ~d : d;
        seenSpi     = 1'b0;
        seenMrdyLow = 1'b0;
        iE          = 1'b1;
        repeat (3) tick();
        checkOutput("selects_before_decode", {o_ram_ce, o_io_ce, o_spi_ce}, 0);
        tick();
        checkOutput("ram_ce", o_ram_ce, kind == K_RAM);
        checkOutput("io_ce", o_io_ce, kind == K_IO);
        checkOutput("spi_ce", o_spi_ce, flashRead);
        checkOutput("mrdy_after_decode", o_MRDY, !flashRead);
        if (kind == K_FLASH && !rw) expWrErr = 1'b1;
        if (flashRead) begin
            if (dropAfter < 0) begin
                repeat (SETTLE_CYCLES - 1) tick();
                checkOutput("mrdy_settle_low", o_MRDY, 0);
                tick();
                checkOutput("mrdy_settle_done", o_MRDY, 1);
                checkOutput("data_repeat", o_DATA, d);
                expData = d;
            end else begin
                repeat (dropAfter) tick();
                iFlashReady = 1'b0;
                if (waitLen < 0) begin
                    n = 0;
                    while (o_MRDY !== 1'b1 && n < 1100) begin
                        tick();
                        n++;
                    end
                    checkOutput("timeout_latency", dropAfter + n, TIMEOUT_CYCLES);
                    expData    = 8'hFF;
                    expTimeout = 1'b1;
                end else begin
                    repeat (waitLen) tick();
                    checkOutput("mrdy_wait_low", o_MRDY, 0);
                    iFlashData  = d;
                    iFlashReady = 1'b1;
                    tick();
                    checkOutput("mrdy_ready_return", o_MRDY, 1);
                    checkOutput("data_ready_return", o_DATA, d);
                    expData = d;
                end
            end
        end
        checkOutput("mrdy_hold", o_MRDY, 1);
        checkOutput("spi_ce_hold", o_spi_ce, flashRead);
        iE = 1'b0;
        repeat (2) tick();
        checkOutput("selects_until_fall", {o_ram_ce, o_io_ce, o_spi_ce},
                    {kind == K_RAM, kind == K_IO, flashRead});
        tick();
        checkOutput("selects_cleared", {o_ram_ce, o_io_ce, o_spi_ce}, 0);
        checkOutput("data", o_DATA, expData);
        checkOutput("timeout_flag", o_flash_timeout, expTimeout);
        checkOutput("wr_err_flag", o_flash_wr_err, expWrErr);
        checkOutput("seen_spi_ce", seenSpi, flashRead);
        checkOutput("seen_mrdy_low", seenMrdyLow, flashRead);
        iVma        = 1'b0;
        iFlashReady = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        rstN        = 1'b0;
        iAddr       = 16'h0000;
        iRw         = 1'b1;
        iVma        = 1'b0;
        iE          = 1'b0;
        iFlashReady = 1'b1;
        iFlashData  = 8'h00;
        expData     = 8'hFF;
        expTimeout  = 1'b0;
        expWrErr    = 1'b0;
        repeat (3) tick();
        checkOutput("reset_mrdy", o_MRDY, 1);
        checkOutput("reset_selects", {o_ram_ce, o_io_ce, o_spi_ce}, 0);
        checkOutput("reset_data", o_DATA, 8'hFF);
        checkOutput("reset_flags", {o_flash_timeout, o_flash_wr_err}, 0);
        rstN  = 1'b1;
        monOn = 1'b1;
        tick();

        applyStimulus(16'h1234, 1'b1, 0, 0, 8'h11);
        applyStimulus(16'hF123, 1'b1, 2, 90, 8'hA5);
        applyStimulus(16'hF456, 1'b1, -1, 0, 8'h3C);
        applyStimulus(16'hF800, 1'b1, 1, -1, 8'h77);
        applyStimulus(16'h0100, 1'b0, 0, 0, 8'h22);
        applyStimulus(16'hF000, 1'b0, 0, 0, 8'h44);
        applyStimulus(16'hE010, 1'b1, 0, 0, 8'h55);
        applyStimulus(16'hE800, 1'b1, 0, 0, 8'h66);
        applyStimulus(16'hDFFF, 1'b1, 0, 0, 8'h88);

        $display("[TB] VMA low cycle");
        iAddr       = 16'h1234;
        iRw         = 1'b1;
        iVma        = 1'b0;
        seenSpi     = 1'b0;
        seenMrdyLow = 1'b0;
        iE          = 1'b1;
        repeat (6) tick();
        checkOutput("novma_selects", {o_ram_ce, o_io_ce, o_spi_ce}, 0);
        checkOutput("novma_mrdy", o_MRDY, 1);
        iE = 1'b0;
        repeat (4) tick();
        checkOutput("novma_selects_after", {o_ram_ce, o_io_ce, o_spi_ce}, 0);

        $display("[TB] randomized cycles");
        for (int i = 0; i < 16; i++) begin
            rSel  = int'($urandom_range(0, 5));
            rData = 8'($urandom);
            rRw   = 1'($urandom_range(0, 1));
            case (rSel)
                0: applyStimulus(16'($urandom_range(0, 16'hDFFF)), rRw, 0, 0, rData);
                1: applyStimulus({8'hE0, 8'($urandom)}, rRw, 0, 0, rData);
                2: applyStimulus(16'($urandom_range(16'hE100, 16'hEFFF)), rRw, 0, 0, rData);
                3: applyStimulus({4'hF, 12'($urandom)}, 1'b1, int'($urandom_range(0, 3)),
                                 int'($urandom_range(1, 150)), rData);
                4: applyStimulus({4'hF, 12'($urandom)}, 1'b1, -1, 0, rData);
                default: applyStimulus({4'hF, 12'($urandom)}, 1'b0, 0, 0, rData);
            endcase
        end

        $display("[TB] reset during flash wait");
        iAddr = 16'hF123;
        iRw   = 1'b1;
        iVma  = 1'b1;
        iE    = 1'b1;
        repeat (4) tick();
        iFlashReady = 1'b0;
        repeat (20) tick();
        checkOutput("midreset_mrdy_before", o_MRDY, 0);
        rstN        = 1'b0;
        iE          = 1'b0;
        iVma        = 1'b0;
        iFlashReady = 1'b1;
        repeat (3) tick();
        checkOutput("midreset_mrdy", o_MRDY, 1);
        checkOutput("midreset_selects", {o_ram_ce, o_io_ce, o_spi_ce}, 0);
        checkOutput("midreset_data", o_DATA, 8'hFF);
        checkOutput("midreset_flags", {o_flash_timeout, o_flash_wr_err}, 0);
        rstN       = 1'b1;
        expData    = 8'hFF;
        expTimeout = 1'b0;
        expWrErr   = 1'b0;
        tick();
        applyStimulus(16'h1234, 1'b1, 0, 0, 8'h99);

        monOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
